// File: rtl/shift_register_sipo_rx_pkg.sv
// rtl/shift_register_sipo_rx_pkg.sv - shared link defaults and receiver state encoding
package shift_register_sipo_rx_pkg;

  localparam int       LINK_WIDTH    = 32;
  localparam logic     LINK_IDLE_VAL = 1'b1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_DATA = DATA,
    S_STOP = STOP
  } rx_state_t;

endpackage

// File: rtl/shift_register_sipo_rx.sv
// rtl/shift_register_sipo_rx.sv - LSB-first framed serial receiver with parallel word output
module shift_register_sipo_rx
  import shift_register_sipo_rx_pkg::*;
#(
  parameter int   WIDTH    = LINK_WIDTH,
  parameter logic IDLE_VAL = LINK_IDLE_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             SI,
  output logic [WIDTH-1:0] PO,
  output logic             valid,
  output logic             frame_error,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_t        state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [WIDTH-1:0] po_next;
  logic             valid_next, frame_error_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      PO          <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      shreg       <= shreg_next;
      PO          <= po_next;
      valid       <= valid_next;
      frame_error <= frame_error_next;
      busy        <= (state_next != S_IDLE);
    end
  end

  // Nothing advances outside strobe cycles, so inter-strobe glitches on SI are ignored.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    shreg_next       = shreg;
    po_next          = PO;
    valid_next       = 1'b0;
    frame_error_next = 1'b0;
    if (enable) begin
      case (state)
        S_IDLE: begin
          if (SI == ~IDLE_VAL) begin
            state_next = S_DATA;
            cnt_next   = '0;
          end
        end
        S_DATA: begin
          shreg_next = {SI, shreg[WIDTH-1:1]};
          if (cnt == LAST_BIT) begin
            state_next = S_STOP;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        S_STOP: begin
          // The stop strobe always returns to IDLE; start detection waits for the next strobe.
          state_next = S_IDLE;
          if (SI == IDLE_VAL) begin
            po_next    = shreg;
            valid_next = 1'b1;
          end else begin
            frame_error_next = 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

endmodule
